data_mem_responder: RTL and testbench

- Data-side memory responder that services the load/store requests issued by the MEM pipeline stage.
- Request bus from MEM: chip-enable, write-enable, byte address, byte-select, write data.
- Owns a word-organised on-chip RAM with byte-lane writes and a programmable wait-state count.
- Returns read data and holds the pipeline through a stall request until the access completes.

---
 rtl/data_mem_responder.sv | 78 +++++++
 tb/tb_data_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage load/store responder with a wait-stated byte-lane word RAM
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  input  logic        stall_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:2] addr_q, addr_c;
  logic we_q, we_c, err_q, idle_req, commit, in_range;
  logic [3:0] sel_q, sel_c;
  logic [31:0] data_q, data_c;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] ram [2**ADDR_WIDTH];
  logic unused_addr;
  assign unused_addr = ^mem_addr_i[1:0];
  assign idle_req = state == IDLE && mem_ce_i;
  // with no wait states the access commits straight from IDLE using the live request
  assign commit = !rst && mem_ce_i && (state == IDLE ? WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0);
  assign addr_c = state == IDLE ? mem_addr_i[31:2] : addr_q;
  assign we_c = state == IDLE ? mem_we_i : we_q;
  assign sel_c = state == IDLE ? mem_sel_i : sel_q;
  assign data_c = state == IDLE ? mem_data_i : data_q;
  assign idx = addr_c[ADDR_WIDTH+1:2];
  assign in_range = addr_c[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: dropping ce while waiting flushes the access
  always_comb
    state_nx = state == IDLE ? (!mem_ce_i ? IDLE : WAIT_CYCLES == 0 ? DONE : WAIT)
             : state == WAIT ? (!mem_ce_i ? IDLE : cnt == 4'd0 ? DONE : WAIT)
             : stall_i ? DONE : IDLE;
  // outputs: stall until the access is done, error flag only while in DONE
  always_comb begin
    stallreq_o = idle_req || state == WAIT;
    bus_err_o = state == DONE && err_q;
  end
  // request latch, wait counter and read-data/error capture at commit
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= 4'd0;
      mem_data_o <= '0;
      err_q <= 1'b0;
    end else begin
      if (idle_req) begin
        addr_q <= mem_addr_i[31:2];
        we_q <= mem_we_i;
        sel_q <= mem_sel_i;
        data_q <= mem_data_i;
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (commit) begin
        mem_data_o <= in_range ? ram[idx] : '0;
        err_q <= !in_range;
      end
    end
  // byte-lane store into the RAM; contents are never reset
  always_ff @(posedge clk)
    if (commit && we_c && in_range)
      for (int i = 0; i < 4; i++)
        if (sel_c[i]) ram[idx][8*i +: 8] <= data_c[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder at 0, 1 and 3 wait states
module tb_data_mem_responder;
  logic clk = 0, rst = 1, we = 0, stall = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] sel = 0;
  logic ce [3] = '{0, 0, 0};
  logic [31:0] dout [3];
  logic sr [3], be [3];
  logic psr [3] = '{0, 0, 0};
  logic pce [3] = '{0, 0, 0};
  logic prst = 1;
  int wc [3] = '{0, 1, 3};
  int tests = 0, fails = 0;
  typedef struct {int d; logic [31:0] dat; logic err; bit kd;} exp_t;
  exp_t sb [$];
  exp_t e;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wdata), .stall_i(stall),
    .mem_data_o(dout[0]), .stallreq_o(sr[0]), .bus_err_o(be[0]));
  data_mem_responder #(.WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wdata), .stall_i(stall),
    .mem_data_o(dout[1]), .stallreq_o(sr[1]), .bus_err_o(be[1]));
  data_mem_responder #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we),
    .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wdata), .stall_i(stall),
    .mem_data_o(dout[2]), .stallreq_o(sr[2]), .bus_err_o(be[2]));

  always @(posedge clk) begin
    pce <= ce;
    prst <= rst;
  end

  // a completed access shows as stallreq falling while the request was still asserted
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (psr[i] && !sr[i] && pce[i] && !prst) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: dut%0d completed with data %h err %b, none expected", i, dout[i], be[i]);
        end else begin
          e = sb.pop_front();
          if (e.d != i || (e.kd && dout[i] !== e.dat) || be[i] !== e.err) begin
            fails++;
            $display("FAIL done_dut%0d: got dut%0d data %h err %b, expected dut%0d data %h err %b",
                     e.d, i, dout[i], be[i], e.d, e.dat, e.err);
          end
        end
      end
      psr[i] = sr[i];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee, input bit kd,
                        input int hold);
    int n = 0;
    sb.push_back('{d, ed, ee, kd});
    @(posedge clk);
    #1 ce[d] = 1; we = w; addr = a; sel = s; wdata = wd;
    @(negedge clk);
    while (sr[d] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("stall_cycles_dut%0d", d), n, wc[d] + 1);
    if (hold > 0) begin
      #1 stall = 1;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_stallreq", sr[d], 0);
        chk("hold_err", be[d], ee);
        if (kd) chk("hold_data", dout[d], ed);
      end
      #1 stall = 0;
    end
    @(negedge clk);
    chk("left_done", sr[d], 1);
    chk("err_one_cycle", be[d], 0);
    #1 ce[d] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_data", dout[i], 0);
      chk("reset_stallreq", sr[i], 0);
      chk("reset_err", be[i], 0);
    end
    access(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
    access(1, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0, 1, 0);
    access(1, 1, 32'h20, 4'hF, 32'h11223344, 0, 0, 0, 0);
    access(1, 1, 32'h20, 4'b0100, 32'h00AA0000, 32'h11223344, 0, 1, 0);
    access(1, 0, 32'h20, 4'hF, 0, 32'h11AA3344, 0, 1, 0);
    access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
    access(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0, 1, 0);
    access(0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 1, 0);
    access(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0, 1, 0);
    access(1, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 0);
    access(1, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 0, 1, 1, 0);
    access(1, 0, 32'h0, 4'hF, 0, 32'hA5A5A5A5, 0, 1, 0);
    access(1, 0, 32'h1000, 4'hF, 0, 0, 1, 1, 0);
    access(2, 1, 32'h30, 4'hF, 32'h12345678, 0, 0, 0, 0);
    access(2, 0, 32'h30, 4'hF, 0, 32'h12345678, 0, 1, 0);
    @(posedge clk);
    #1 ce[2] = 1; we = 1; addr = 32'h30; sel = 4'hF; wdata = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #1 ce[2] = 0;
    @(negedge clk);
    chk("flush_wait_stallreq", sr[2], 1);
    @(negedge clk);
    chk("flush_idle_stallreq", sr[2], 0);
    access(2, 0, 32'h30, 4'hF, 0, 32'h12345678, 0, 1, 0);
    @(posedge clk);
    #1 ce[2] = 1; we = 1; addr = 32'h30; sel = 4'hF; wdata = 32'h55;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; ce[2] = 0;
    @(negedge clk);
    chk("rst_stallreq", sr[2], 0);
    chk("rst_data", dout[2], 0);
    chk("rst_err", be[2], 0);
    access(2, 0, 32'h30, 4'hF, 0, 32'h12345678, 0, 1, 0);
    access(1, 0, 32'h20, 4'hF, 0, 32'h11AA3344, 0, 1, 3);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
